br_checkpoint_stack: RTL and testbench

//  Parametrised branch checkpoint stack for the R10K rename stage. Allocates a one-hot tag to

---
 rtl/br_checkpoint_stack_pkg.sv | 40 ++++
 rtl/br_checkpoint_stack_tag_alloc.sv | 26 ++
 rtl/br_checkpoint_stack.sv | 102 ++++++++++
 tb/tb_br_checkpoint_stack.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/br_checkpoint_stack_pkg.sv
// Shared sizes, types and helpers for the branch checkpoint stack.
package br_checkpoint_stack_pkg;

  localparam int BR_DEPTH  = 5;
  localparam int ARCH_REGS = 32;
  localparam int PREG_W    = 6;
  localparam int FL_PTR_W  = 5;
  localparam int CNT_W     = $clog2(BR_DEPTH + 1);
  localparam int IDX_W     = (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1;

  typedef logic [BR_DEPTH-1:0]         br_mask_t;
  typedef logic [ARCH_REGS*PREG_W-1:0] map_img_t;
  typedef logic [FL_PTR_W-1:0]         fl_ptr_t;

  typedef struct packed {
    map_img_t mt;
    fl_ptr_t  fl_head;
    br_mask_t parent;
  } checkpoint_t;

  // One-hot tag to slot index; a zero or multi-hot input is never used downstream.
  function automatic logic [IDX_W-1:0] oh_to_idx(input br_mask_t m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      if (m[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input br_mask_t m);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      cnt = cnt + CNT_W'(m[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/br_checkpoint_stack_tag_alloc.sv
// Finds the lowest free tag in a live-tag mask.
module br_checkpoint_stack_tag_alloc #(
  parameter int W  = 5,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask_i,
  output logic [W-1:0]  tag_o,
  output logic [IW-1:0] idx_o,
  output logic          any_free_o
);

  // Priority scan from bit 0 upward; first zero wins.
  always_comb begin
    tag_o      = '0;
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!mask_i[i] && !any_free_o) begin
        tag_o[i]   = 1'b1;
        idx_o      = IW'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_checkpoint_stack.sv
// Branch checkpoint stack: tag allocation, map/free-list snapshots, squash and recovery.
module br_checkpoint_stack
  import br_checkpoint_stack_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_disp_i,
  input  logic [ARCH_REGS*PREG_W-1:0]   bak_mt_data_i,
  input  logic [FL_PTR_W-1:0]           bak_fl_head_i,
  input  logic                          br_rslv_valid_i,
  input  logic                          br_rslv_wrong_i,
  input  logic [BR_DEPTH-1:0]           br_rslv_tag_i,
  output logic [BR_DEPTH-1:0]           br_tag_o,
  output logic [BR_DEPTH-1:0]           br_mask_o,
  output logic [BR_DEPTH-1:0]           br_clr_bit_o,
  output logic [BR_DEPTH-1:0]           squash_mask_o,
  output logic                          rc_valid_o,
  output logic [ARCH_REGS*PREG_W-1:0]   rc_mt_data_o,
  output logic [FL_PTR_W-1:0]           rc_fl_head_o,
  output logic                          full_o,
  output logic [CNT_W-1:0]              free_cnt_o
);

  br_mask_t         r_mask;
  checkpoint_t      r_ckpt [BR_DEPTH];

  br_mask_t         w_alloc_tag;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_any_free;
  logic             w_full;
  logic             w_rslv_ok;
  logic             w_correct;
  logic             w_wrong;
  logic             w_disp_ok;
  logic [IDX_W-1:0] w_rslv_idx;
  br_mask_t         w_clr_tag;
  br_mask_t         w_younger;
  checkpoint_t      w_sel_ckpt;

  br_checkpoint_stack_tag_alloc #(.W(BR_DEPTH), .IW(IDX_W)) u_tag_alloc (
    .mask_i     (r_mask),
    .tag_o      (w_alloc_tag),
    .idx_o      (w_alloc_idx),
    .any_free_o (w_any_free)
  );

  // Qualify the resolution (live, one-hot) and the dispatch; build all same-cycle outputs.
  always_comb begin
    w_full     = &r_mask;
    w_rslv_ok  = ~rst & br_rslv_valid_i & $onehot(br_rslv_tag_i) & (|(br_rslv_tag_i & r_mask));
    w_correct  = w_rslv_ok & ~br_rslv_wrong_i;
    w_wrong    = w_rslv_ok & br_rslv_wrong_i;
    // A raw wrong resolution flushes the front end even if the tag turns out to be bogus.
    w_disp_ok  = ~rst & br_disp_i & ~w_full & w_any_free & ~(br_rslv_valid_i & br_rslv_wrong_i);
    w_rslv_idx = oh_to_idx(br_rslv_tag_i);
    w_clr_tag  = w_correct ? br_rslv_tag_i : '0;
    w_sel_ckpt = r_ckpt[w_rslv_idx];
    w_younger  = '0;
    for (int i = 0; i < BR_DEPTH; i++) begin
      w_younger[i] = r_mask[i] & (|(r_ckpt[i].parent & br_rslv_tag_i));
    end

    br_tag_o      = w_disp_ok ? w_alloc_tag : '0;
    br_clr_bit_o  = w_clr_tag;
    rc_valid_o    = w_wrong;
    rc_mt_data_o  = w_wrong ? w_sel_ckpt.mt : '0;
    rc_fl_head_o  = w_wrong ? w_sel_ckpt.fl_head : '0;
    squash_mask_o = w_wrong ? (br_rslv_tag_i | w_younger) : '0;
    br_mask_o     = r_mask;
    full_o        = w_full;
    free_cnt_o    = CNT_W'(BR_DEPTH) - popcnt(r_mask);
  end

  // Live-tag mask: restore parent on mispredict, else retire cleared tag and add new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (w_wrong) begin
      r_mask <= w_sel_ckpt.parent;
    end else begin
      r_mask <= (r_mask & ~w_clr_tag) | (w_disp_ok ? w_alloc_tag : '0);
    end
  end

  // Checkpoint slots: drop cleared tag from every parent, then capture the dispatching branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BR_DEPTH; i++) begin
        r_ckpt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BR_DEPTH; i++) begin
        r_ckpt[i].parent <= r_ckpt[i].parent & ~w_clr_tag;
      end
      if (w_disp_ok) begin
        r_ckpt[w_alloc_idx] <= '{mt: bak_mt_data_i, fl_head: bak_fl_head_i,
                                 parent: r_mask & ~w_clr_tag};
      end
    end
  end

endmodule

// File: tb/tb_br_checkpoint_stack.sv
// Directed bench for br_checkpoint_stack with hand-computed expectations.
module tb_br_checkpoint_stack;
  import br_checkpoint_stack_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        br_disp_i;
  logic [ARCH_REGS*PREG_W-1:0] bak_mt_data_i;
  logic [FL_PTR_W-1:0]         bak_fl_head_i;
  logic                        br_rslv_valid_i;
  logic                        br_rslv_wrong_i;
  logic [BR_DEPTH-1:0]         br_rslv_tag_i;
  logic [BR_DEPTH-1:0]         br_tag_o;
  logic [BR_DEPTH-1:0]         br_mask_o;
  logic [BR_DEPTH-1:0]         br_clr_bit_o;
  logic [BR_DEPTH-1:0]         squash_mask_o;
  logic                        rc_valid_o;
  logic [ARCH_REGS*PREG_W-1:0] rc_mt_data_o;
  logic [FL_PTR_W-1:0]         rc_fl_head_o;
  logic                        full_o;
  logic [CNT_W-1:0]            free_cnt_o;

  int checks   = 0;
  int failures = 0;

  br_checkpoint_stack dut (
    .clk             (clk),
    .rst             (rst),
    .br_disp_i       (br_disp_i),
    .bak_mt_data_i   (bak_mt_data_i),
    .bak_fl_head_i   (bak_fl_head_i),
    .br_rslv_valid_i (br_rslv_valid_i),
    .br_rslv_wrong_i (br_rslv_wrong_i),
    .br_rslv_tag_i   (br_rslv_tag_i),
    .br_tag_o        (br_tag_o),
    .br_mask_o       (br_mask_o),
    .br_clr_bit_o    (br_clr_bit_o),
    .squash_mask_o   (squash_mask_o),
    .rc_valid_o      (rc_valid_o),
    .rc_mt_data_o    (rc_mt_data_o),
    .rc_fl_head_o    (rc_fl_head_o),
    .full_o          (full_o),
    .free_cnt_o      (free_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [ARCH_REGS*PREG_W-1:0] mk_mt(input int k);
    logic [ARCH_REGS*PREG_W-1:0] v;
    for (int r = 0; r < ARCH_REGS; r++) v[r*PREG_W +: PREG_W] = PREG_W'(k + r);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic disp, input int mt_k, input int fl,
                       input logic rv, input logic rw, input logic [BR_DEPTH-1:0] rtag);
    br_disp_i       = disp;
    bak_mt_data_i   = mk_mt(mt_k);
    bak_fl_head_i   = FL_PTR_W'(fl);
    br_rslv_valid_i = rv;
    br_rslv_wrong_i = rw;
    br_rslv_tag_i   = rtag;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic disp(input int mt_k, input int fl, input logic [BR_DEPTH-1:0] exp_tag, input string tag);
    drive(1'b1, mt_k, fl, 1'b0, 1'b0, '0);
    chk(tag, br_tag_o, exp_tag);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0, '0);

    // 1: reset state, then fill all tags
    do_reset();
    chk("rst_mask", br_mask_o, 5'b00000);
    chk("rst_full", full_o, 1'b0);
    chk("rst_free", free_cnt_o, 3'd5);
    chk("rst_tag", br_tag_o, 5'b00000);
    chk("rst_rcv", rc_valid_o, 1'b0);
    chk("rst_sq", squash_mask_o, 5'b00000);
    chk("rst_clr", br_clr_bit_o, 5'b00000);
    chk("rst_rcfl", rc_fl_head_o, 5'd0);
    disp(1, 1, 5'b00001, "t1_d0");
    disp(2, 2, 5'b00010, "t1_d1");
    disp(3, 3, 5'b00100, "t1_d2");
    chk("t1_free3", free_cnt_o, 3'd2);
    disp(4, 4, 5'b01000, "t1_d3");
    disp(5, 5, 5'b10000, "t1_d4");
    disp(6, 6, 5'b00000, "t1_d5");
    chk("t1_full", full_o, 1'b1);
    chk("t1_free", free_cnt_o, 3'd0);
    chk("t1_mask", br_mask_o, 5'b11111);

    // 2: correct A then wrong B
    do_reset();
    disp(10, 1, 5'b00001, "t2_dA");
    disp(20, 2, 5'b00010, "t2_dB");
    disp(30, 3, 5'b00100, "t2_dC");
    drive(1'b0, 0, 0, 1'b1, 1'b0, 5'b00001);
    chk("t2_clr", br_clr_bit_o, 5'b00001);
    chk("t2_crcv", rc_valid_o, 1'b0);
    chk("t2_csq", squash_mask_o, 5'b00000);
    tick();
    chk("t2_mask1", br_mask_o, 5'b00110);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00010);
    chk("t2_rcv", rc_valid_o, 1'b1);
    chk("t2_sq", squash_mask_o, 5'b00110);
    chk("t2_rcmt", rc_mt_data_o, mk_mt(20));
    chk("t2_rcfl", rc_fl_head_o, 5'd2);
    chk("t2_wclr", br_clr_bit_o, 5'b00000);
    tick();
    chk("t2_mask2", br_mask_o, 5'b00000);

    // 3: four live, mispredict the second
    do_reset();
    disp(3, 3, 5'b00001, "t3_dA");
    disp(7, 7, 5'b00010, "t3_dB");
    disp(9, 9, 5'b00100, "t3_dC");
    disp(12, 12, 5'b01000, "t3_dD");
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00010);
    chk("t3_sq", squash_mask_o, 5'b01110);
    chk("t3_rcfl", rc_fl_head_o, 5'd7);
    chk("t3_rcmt", rc_mt_data_o, mk_mt(7));
    tick();
    chk("t3_mask", br_mask_o, 5'b00001);
    chk("t3_free", free_cnt_o, 3'd4);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00001);
    chk("t3_rcfl_a", rc_fl_head_o, 5'd3);
    chk("t3_sq_a", squash_mask_o, 5'b00001);
    tick();
    chk("t3_mask_a", br_mask_o, 5'b00000);

    // 4: full, correct middle tag with dispatch same cycle, reuse next cycle
    do_reset();
    for (int k = 0; k < 5; k++) disp(k, k, 5'(1 << k), "t4_fill");
    drive(1'b1, 8, 8, 1'b1, 1'b0, 5'b00100);
    chk("t4_tag0", br_tag_o, 5'b00000);
    chk("t4_clr", br_clr_bit_o, 5'b00100);
    tick();
    chk("t4_mask", br_mask_o, 5'b11011);
    chk("t4_full", full_o, 1'b0);
    chk("t4_free", free_cnt_o, 3'd1);
    drive(1'b1, 8, 8, 1'b0, 1'b0, '0);
    chk("t4_reuse", br_tag_o, 5'b00100);
    tick();
    chk("t4_mask2", br_mask_o, 5'b11111);
    // reused slot 2 was dispatched after all others; mispredicting it kills only itself
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00100);
    chk("t4_sq", squash_mask_o, 5'b00100);
    chk("t4_rcfl", rc_fl_head_o, 5'd8);
    tick();
    chk("t4_mask3", br_mask_o, 5'b11011);

    // 5: dispatch dropped under mispredict; bogus resolutions ignored
    do_reset();
    disp(4, 4, 5'b00001, "t5_dA");
    drive(1'b1, 21, 21, 1'b1, 1'b1, 5'b00001);
    chk("t5_tag0", br_tag_o, 5'b00000);
    chk("t5_sq", squash_mask_o, 5'b00001);
    chk("t5_rcfl", rc_fl_head_o, 5'd4);
    tick();
    chk("t5_mask", br_mask_o, 5'b00000);
    disp(5, 5, 5'b00001, "t5_dA2");
    drive(1'b0, 0, 0, 1'b1, 1'b0, 5'b00100);
    chk("t5_nl_clr", br_clr_bit_o, 5'b00000);
    tick();
    chk("t5_nl_mask", br_mask_o, 5'b00001);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b01000);
    chk("t5_nl_rcv", rc_valid_o, 1'b0);
    chk("t5_nl_sq", squash_mask_o, 5'b00000);
    chk("t5_nl_rcfl", rc_fl_head_o, 5'd0);
    tick();
    chk("t5_nl_mask2", br_mask_o, 5'b00001);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00011);
    chk("t5_mh_rcv", rc_valid_o, 1'b0);
    tick();
    chk("t5_mh_mask", br_mask_o, 5'b00001);

    // 6: reset wins over a concurrent mispredict
    do_reset();
    disp(1, 1, 5'b00001, "t6_d0");
    disp(2, 2, 5'b00010, "t6_d1");
    disp(3, 3, 5'b00100, "t6_d2");
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b1, 1'b1, 5'b00010);
    tick();
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0, '0);
    chk("t6_mask", br_mask_o, 5'b00000);
    chk("t6_rcv", rc_valid_o, 1'b0);
    chk("t6_free", free_cnt_o, 3'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
